// File: rtl/byte_word_assembler.sv
// Packs a stream of received bytes into one NUM_BYTES-wide word, first byte in the MSB lane.
// Partial words are padded with PAD_BYTE and emitted on idle timeout or flush.
module byte_word_assembler #(
  parameter int         NUM_BYTES      = 6,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] PAD_BYTE       = 8'h00
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [7:0]                       byte_in,
  input  logic                             byte_valid,
  output logic                             byte_ready,
  input  logic                             flush,
  output logic [8*NUM_BYTES-1:0]           data_out,
  output logic                             data_valid,
  output logic                             partial,
  output logic [$clog2(NUM_BYTES+1)-1:0]   byte_cnt
);

  localparam int CNT_W  = $clog2(NUM_BYTES + 1);
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WORD_W = 8 * NUM_BYTES;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EMIT = 2'd2
  } state_t;

  state_t              state_r;
  state_t              next_state_s;
  logic [WORD_W-1:0]   word_r;
  logic [WORD_W-1:0]   word_s;
  logic [WORD_W-1:0]   next_word_s;
  logic [CNT_W-1:0]    byte_cnt_r;
  logic [CNT_W-1:0]    next_cnt_s;
  logic [CNT_W-1:0]    cnt_inc_s;
  logic [IDLE_W-1:0]   idle_r;
  logic [IDLE_W-1:0]   next_idle_s;
  logic [IDLE_W-1:0]   idle_inc_s;
  logic                next_partial_s;
  logic                accept_s;
  logic                full_s;
  logic                ready_r;
  logic [WORD_W-1:0]   data_out_r;
  logic                data_valid_r;
  logic                partial_r;

  assign accept_s   = byte_valid && ready_r;
  assign cnt_inc_s  = byte_cnt_r + CNT_W'(1);
  assign full_s     = (cnt_inc_s == CNT_W'(NUM_BYTES));
  assign idle_inc_s = (idle_r == IDLE_W'(TIMEOUT_CYCLES)) ? idle_r : idle_r + IDLE_W'(1);

  // Lane buffer with the incoming byte merged into the lane selected by byte_cnt
  always_comb begin
    word_s = word_r;
    for (int i = 0; i < NUM_BYTES; i++) begin
      word_s[8*(NUM_BYTES-1-i) +: 8] = (accept_s && (byte_cnt_r == CNT_W'(i))) ?
                                       byte_in : word_r[8*(NUM_BYTES-1-i) +: 8];
    end
  end

  // Next-state and datapath update decisions
  always_comb begin
    next_state_s   = state_r;
    next_word_s    = word_r;
    next_cnt_s     = byte_cnt_r;
    next_idle_s    = idle_r;
    next_partial_s = partial_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          next_word_s = word_s;
          next_cnt_s  = cnt_inc_s;
          next_idle_s = {IDLE_W{1'b0}};
          if (full_s) begin
            next_state_s   = ST_EMIT;
            next_partial_s = 1'b0;
          end else begin
            next_state_s = ST_FILL;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (accept_s) begin
          next_word_s = word_s;
          next_cnt_s  = cnt_inc_s;
          next_idle_s = {IDLE_W{1'b0}};
          if (full_s) begin
            next_state_s   = ST_EMIT;
            next_partial_s = 1'b0;
          end else if (flush) begin
            next_state_s   = ST_EMIT;
            next_partial_s = 1'b1;
          end else begin
            next_state_s = ST_FILL;
          end
        end else begin
          next_idle_s = idle_inc_s;
          // Unfilled lanes already hold PAD_BYTE, so a padded emit needs no extra merge
          if (flush || (idle_inc_s >= IDLE_W'(TIMEOUT_CYCLES))) begin
            next_state_s   = ST_EMIT;
            next_partial_s = 1'b1;
          end else begin
            next_state_s = ST_FILL;
          end
        end
      end
      ST_EMIT: begin
        next_state_s = ST_IDLE;
        next_word_s  = {NUM_BYTES{PAD_BYTE}};
        next_cnt_s   = {CNT_W{1'b0}};
        next_idle_s  = {IDLE_W{1'b0}};
      end
      default: begin
        next_state_s = ST_IDLE;
        next_word_s  = {NUM_BYTES{PAD_BYTE}};
        next_cnt_s   = {CNT_W{1'b0}};
        next_idle_s  = {IDLE_W{1'b0}};
      end
    endcase
  end

  // State, lane buffer and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      word_r     <= {NUM_BYTES{PAD_BYTE}};
      byte_cnt_r <= {CNT_W{1'b0}};
      idle_r     <= {IDLE_W{1'b0}};
    end else begin
      state_r    <= next_state_s;
      word_r     <= next_word_s;
      byte_cnt_r <= next_cnt_s;
      idle_r     <= next_idle_s;
    end
  end

  // Registered outputs, all updated on the edge that enters EMIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r      <= 1'b0;
      data_out_r   <= {WORD_W{1'b0}};
      data_valid_r <= 1'b0;
      partial_r    <= 1'b0;
    end else begin
      ready_r      <= (next_state_s != ST_EMIT);
      data_valid_r <= (next_state_s == ST_EMIT);
      if (next_state_s == ST_EMIT) begin
        data_out_r <= next_word_s;
        partial_r  <= next_partial_s;
      end else begin
        data_out_r <= data_out_r;
        partial_r  <= partial_r;
      end
    end
  end

  assign byte_ready = ready_r;
  assign data_out   = data_out_r;
  assign data_valid = data_valid_r;
  assign partial    = partial_r;
  assign byte_cnt   = byte_cnt_r;

endmodule
